// File: rtl/cordic_vector_engine.sv
// Iterative CORDIC vectoring engine: (x,y) -> K*|(x,y)| and atan2(y,x) in Q2.13 rad.
// One micro-rotation per clock through three small ALUs; done pulses N_ITER edges after start.

module cordic_alu #(
  parameter int WORD_WIDTH = 16
) (
  input  logic        [1:0]            op,
  input  logic signed [WORD_WIDTH-1:0] a,
  input  logic signed [WORD_WIDTH-1:0] b,
  output logic signed [WORD_WIDTH-1:0] result
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;

  always_comb begin
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      default: result = a;
    endcase
  end

endmodule

module cordic_vector_engine #(
  parameter int WORD_WIDTH = 16,
  parameter int N_ITER     = 12,
  parameter int ITER_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [WORD_WIDTH-1:0] x_in,
  input  logic signed [WORD_WIDTH-1:0] y_in,
  output logic                         busy,
  output logic                         done,
  output logic signed [WORD_WIDTH-1:0] x_out,
  output logic signed [WORD_WIDTH-1:0] z_out
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_NOP = 2'd2;

  localparam logic [ITER_W-1:0]            LAST_ITER = ITER_W'(N_ITER - 1);
  localparam logic signed [WORD_WIDTH-1:0] PI_Q     = WORD_WIDTH'(25736);

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t state;

  logic        [ITER_W-1:0]     iter;
  logic signed [WORD_WIDTH-1:0] x_r;
  logic signed [WORD_WIDTH-1:0] y_r;
  logic signed [WORD_WIDTH-1:0] z_r;

  logic                         dir;
  logic signed [WORD_WIDTH-1:0] x_shift;
  logic signed [WORD_WIDTH-1:0] y_shift;
  logic signed [WORD_WIDTH-1:0] atan_val;

  logic        [1:0]            x_op;
  logic        [1:0]            y_op;
  logic        [1:0]            z_op;
  logic signed [WORD_WIDTH-1:0] x_next;
  logic signed [WORD_WIDTH-1:0] y_next;
  logic signed [WORD_WIDTH-1:0] z_next;

  // Y==0 is treated as positive, so a zero vector rotates clockwise every step.
  assign dir     = ~y_r[WORD_WIDTH-1];
  assign x_shift = x_r >>> iter;
  assign y_shift = y_r >>> iter;

  always_comb begin
    case (iter)
      4'd0:    atan_val = WORD_WIDTH'(6434);
      4'd1:    atan_val = WORD_WIDTH'(3798);
      4'd2:    atan_val = WORD_WIDTH'(2007);
      4'd3:    atan_val = WORD_WIDTH'(1019);
      4'd4:    atan_val = WORD_WIDTH'(511);
      4'd5:    atan_val = WORD_WIDTH'(256);
      4'd6:    atan_val = WORD_WIDTH'(128);
      4'd7:    atan_val = WORD_WIDTH'(64);
      4'd8:    atan_val = WORD_WIDTH'(32);
      4'd9:    atan_val = WORD_WIDTH'(16);
      4'd10:   atan_val = WORD_WIDTH'(8);
      4'd11:   atan_val = WORD_WIDTH'(4);
      4'd12:   atan_val = WORD_WIDTH'(2);
      4'd13:   atan_val = WORD_WIDTH'(1);
      default: atan_val = '0;
    endcase
  end

  always_comb begin
    x_op = OP_NOP;
    y_op = OP_NOP;
    z_op = OP_NOP;
    if (state == ITER) begin
      x_op = dir ? OP_ADD : OP_SUB;
      y_op = dir ? OP_SUB : OP_ADD;
      z_op = dir ? OP_ADD : OP_SUB;
    end
  end

  cordic_alu #(.WORD_WIDTH(WORD_WIDTH)) u_alu_x (
    .op     (x_op),
    .a      (x_r),
    .b      (y_shift),
    .result (x_next)
  );

  cordic_alu #(.WORD_WIDTH(WORD_WIDTH)) u_alu_y (
    .op     (y_op),
    .a      (y_r),
    .b      (x_shift),
    .result (y_next)
  );

  cordic_alu #(.WORD_WIDTH(WORD_WIDTH)) u_alu_z (
    .op     (z_op),
    .a      (z_r),
    .b      (atan_val),
    .result (z_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      iter  <= '0;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      x_out <= '0;
      z_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Left half-plane inputs are rotated by pi so the iterations only cover +/-pi/2.
            if (x_in[WORD_WIDTH-1]) begin
              x_r <= -x_in;
              y_r <= -y_in;
              z_r <= y_in[WORD_WIDTH-1] ? -PI_Q : PI_Q;
            end else begin
              x_r <= x_in;
              y_r <= y_in;
              z_r <= '0;
            end
            iter  <= '0;
            busy  <= 1'b1;
            state <= ITER;
          end
        end
        ITER: begin
          x_r  <= x_next;
          y_r  <= y_next;
          z_r  <= z_next;
          iter <= iter + 1'b1;
          if (iter == LAST_ITER) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            x_out <= x_next;
            z_out <= z_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
